seg7_frame_decoder: RTL and testbench

//  Inverse of the hex-to-7-segment LUT path: samples the eight active-low

---
 rtl/seg7_pkg.sv | 21 ++
 rtl/seg7_pattern_dec.sv | 24 ++
 rtl/seg7_frame_decoder.sv | 124 ++++++++++++
 tb/tb_seg7_frame_decoder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display chain: blank pattern, the active-low
// hex glyph table and the decoded frame record.
package seg7_pkg;

    localparam int unsigned NUM_DIG = 8;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Entry i is the active-low {g,f,e,d,c,b,a} glyph for hex digit i.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef struct packed {
        logic [NUM_DIG*4-1:0] dig;
        logic [NUM_DIG-1:0]   blank;
        logic [NUM_DIG-1:0]   err;
    } frame_t;

endpackage

// File: rtl/seg7_pattern_dec.sv
// Combinational inverse of the hex glyph LUT: one 7-bit active-low segment
// pattern to a digit plus blank/error flags.
module seg7_pattern_dec
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       blank,
    output logic       err
);

    always_comb begin
        digit = 4'd0;
        blank = (seg == SEG_BLANK);
        err   = (seg != SEG_BLANK);
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_TABLE[i]) begin
                digit = 4'(i);
                err   = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg7_frame_decoder.sv
// Scans the eight display segment buses through one shared decoder and commits
// the decoded digit frame once it has been identical for STABLE_FRAMES scans.
module seg7_frame_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_FRAMES = 4,
    parameter int unsigned CNT_W         = 4
) (
    input  logic        CLOCK_50,
    input  logic        rst,
    input  logic [6:0]  iSEG0,
    input  logic [6:0]  iSEG1,
    input  logic [6:0]  iSEG2,
    input  logic [6:0]  iSEG3,
    input  logic [6:0]  iSEG4,
    input  logic [6:0]  iSEG5,
    input  logic [6:0]  iSEG6,
    input  logic [6:0]  iSEG7,
    output logic [31:0] oDIG,
    output logic [7:0]  oBLANK,
    output logic [7:0]  oERR,
    output logic        oVALID,
    output logic        oCHANGED
);

    localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_FRAMES - 1);

    logic [2:0]       idx_q;
    logic [6:0]       cur_seg;
    logic [3:0]       dec_digit;
    logic             dec_blank;
    logic             dec_err;
    frame_t           shadow_q, shadow_d, prev_q;
    logic [CNT_W-1:0] stab_q, stab_d;
    logic             frame_done, frame_eq, commit, data_changed;
    logic [31:0]      dig_q;
    logic [7:0]       blank_q, err_q;
    logic             valid_q, changed_q, first_q;

    always_comb begin
        unique case (idx_q)
            3'd0:    cur_seg = iSEG0;
            3'd1:    cur_seg = iSEG1;
            3'd2:    cur_seg = iSEG2;
            3'd3:    cur_seg = iSEG3;
            3'd4:    cur_seg = iSEG4;
            3'd5:    cur_seg = iSEG5;
            3'd6:    cur_seg = iSEG6;
            default: cur_seg = iSEG7;
        endcase
    end

    seg7_pattern_dec u_dec (
        .seg   (cur_seg),
        .digit (dec_digit),
        .blank (dec_blank),
        .err   (dec_err)
    );

    // The frame compared at idx 7 must include the entry decoded this cycle.
    always_comb begin
        shadow_d                         = shadow_q;
        shadow_d.dig[{idx_q, 2'b00} +: 4] = dec_digit;
        shadow_d.blank[idx_q]            = dec_blank;
        shadow_d.err[idx_q]              = dec_err;
    end

    assign frame_done   = (idx_q == 3'd7);
    assign frame_eq     = (shadow_d == prev_q);
    assign data_changed = ({shadow_d.dig, shadow_d.blank, shadow_d.err}
                           != {dig_q, blank_q, err_q});

    always_comb begin
        stab_d = stab_q;
        if (frame_done) begin
            if (!frame_eq) begin
                stab_d = '0;
            end else if (stab_q != STAB_LAST) begin
                stab_d = stab_q + 1'b1;
            end
        end
    end

    // Commit only on the step that reaches the threshold; holding there blocks repeats.
    assign commit = frame_done && frame_eq && (stab_q != STAB_LAST) && (stab_d == STAB_LAST);

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            idx_q     <= 3'd0;
            shadow_q  <= '0;
            prev_q    <= '0;
            stab_q    <= '0;
            dig_q     <= 32'd0;
            blank_q   <= 8'hFF;
            err_q     <= 8'd0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
            first_q   <= 1'b1;
        end else begin
            idx_q     <= idx_q + 3'd1;
            shadow_q  <= shadow_d;
            stab_q    <= stab_d;
            valid_q   <= commit;
            changed_q <= 1'b0;
            if (frame_done && !frame_eq) begin
                prev_q <= shadow_d;
            end
            if (commit) begin
                dig_q     <= shadow_d.dig;
                blank_q   <= shadow_d.blank;
                err_q     <= shadow_d.err;
                changed_q <= first_q || data_changed;
                first_q   <= 1'b0;
            end
        end
    end

    assign oDIG     = dig_q;
    assign oBLANK   = blank_q;
    assign oERR     = err_q;
    assign oVALID   = valid_q;
    assign oCHANGED = changed_q;

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Directed and randomized bench for seg7_frame_decoder against a frame-level
// reference model built from the glyph table and the stability/commit rules.
module tb_seg7_frame_decoder;

    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg_in [8];
    logic [31:0] oDIG;
    logic [7:0]  oBLANK, oERR;
    logic        oVALID, oCHANGED;

    int checks   = 0;
    int failures = 0;

    logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model state
    int          m_idx, m_cnt;
    bit          m_first;
    logic [47:0] m_shadow, m_prev;
    logic [31:0] e_dig;
    logic [7:0]  e_bl, e_er;
    logic        e_valid, e_chg;

    int   vcount;
    logic last_chg;

    seg7_frame_decoder #(.STABLE_FRAMES(STABLE), .CNT_W(4)) dut (
        .CLOCK_50 (clk),
        .rst      (rst),
        .iSEG0    (seg_in[0]),
        .iSEG1    (seg_in[1]),
        .iSEG2    (seg_in[2]),
        .iSEG3    (seg_in[3]),
        .iSEG4    (seg_in[4]),
        .iSEG5    (seg_in[5]),
        .iSEG6    (seg_in[6]),
        .iSEG7    (seg_in[7]),
        .oDIG     (oDIG),
        .oBLANK   (oBLANK),
        .oERR     (oERR),
        .oVALID   (oVALID),
        .oCHANGED (oCHANGED)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void ref_decode(input logic [6:0] p, output int d, output bit bl,
                                       output bit er);
        d  = 0;
        bl = (p == 7'h7F);
        er = !bl;
        for (int i = 0; i < 16; i++) begin
            if (tbl[i] == p) begin
                d  = i;
                er = 1'b0;
            end
        end
    endfunction

    // Frame packed as {32-bit digits, 8 blank bits, 8 err bits}.
    task automatic model_step();
        int d;
        bit bl, er;
        if (rst) begin
            m_idx = 0; m_cnt = 0; m_first = 1'b1;
            m_shadow = '0; m_prev = '0;
            e_dig = 32'd0; e_bl = 8'hFF; e_er = 8'd0; e_valid = 1'b0; e_chg = 1'b0;
        end else begin
            ref_decode(seg_in[m_idx], d, bl, er);
            m_shadow[16 + m_idx*4 +: 4] = 4'(d);
            m_shadow[8 + m_idx]         = bl;
            m_shadow[m_idx]             = er;
            e_valid = 1'b0;
            e_chg   = 1'b0;
            if (m_idx == 7) begin
                if (m_shadow == m_prev) begin
                    if (m_cnt < STABLE - 1) begin
                        m_cnt++;
                        if (m_cnt == STABLE - 1) begin
                            e_chg   = m_first || (m_shadow != {e_dig, e_bl, e_er});
                            {e_dig, e_bl, e_er} = m_shadow;
                            e_valid = 1'b1;
                            m_first = 1'b0;
                        end
                    end
                end else begin
                    m_cnt  = 0;
                    m_prev = m_shadow;
                end
            end
            m_idx = (m_idx + 1) % 8;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("valid", oVALID, e_valid);
        check("dig", oDIG, e_dig);
        check("blank", oBLANK, e_bl);
        check("err", oERR, e_er);
        if (e_valid) check("changed", oCHANGED, e_chg);
        if (oVALID === 1'b1) begin
            vcount++;
            last_chg = oCHANGED;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Ticks until a commit pulse is seen, bounded; returns the tick count or -1.
    task automatic wait_valid(output int n);
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (oVALID === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        logic [31:0] tmp;
        int k;

        for (int i = 0; i < 8; i++) seg_in[i] = 7'h7F;
        rst = 1'b1;
        run(2);
        check("rst_dig", oDIG, 32'd0);
        check("rst_blank", oBLANK, 8'hFF);
        check("rst_valid", oVALID, 1'b0);
        rst = 1'b0;

        // 1: all blank
        vcount = 0;
        wait_valid(n);
        check("t1_latency", n, 32);
        check("t1_changed", oCHANGED, 1'b1);
        run(30);
        check("t1_count", vcount, 1);
        check("t1_blank", oBLANK, 8'hFF);
        check("t1_dig", oDIG, 32'd0);

        // 2: digits 7..0
        for (int i = 0; i < 8; i++) seg_in[i] = tbl[i];
        vcount = 0;
        run(48);
        check("t2_count", vcount, 1);
        check("t2_dig", oDIG, 32'h76543210);
        check("t2_blank", oBLANK, 8'h00);
        vcount = 0;
        run(48);
        check("t2_hold", vcount, 0);

        // 3: glitch iSEG0 across the idx-0 sample
        while (m_idx != 0) tick();
        vcount = 0;
        seg_in[0] = 7'h79;
        run(5);
        seg_in[0] = 7'h40;
        run(48);
        check("t3_count", vcount, 1);
        check("t3_changed", last_chg, 1'b0);
        check("t3_dig", oDIG, 32'h76543210);

        // 4: illegal pattern on digit 3
        seg_in[3] = 7'h55;
        vcount = 0;
        run(48);
        check("t4_count", vcount, 1);
        check("t4_err", oERR, 8'h08);
        tmp = oDIG;
        check("t4_dig3", tmp[15:12], 4'd0);

        // 5: sweep digit 0 through every glyph
        seg_in[3] = tbl[3];
        seg_in[0] = 7'h7F;
        run(48);
        for (int d = 0; d < 16; d++) begin
            seg_in[0] = tbl[d];
            vcount = 0;
            run(48);
            check("t5_count", vcount, 1);
            check("t5_changed", last_chg, 1'b1);
            tmp = oDIG;
            check("t5_dig0", tmp[3:0], d);
        end

        // 6: reset mid-frame during a stable run
        for (int i = 0; i < 8; i++) seg_in[i] = tbl[$urandom_range(1, 15)];
        run(48);
        while (m_idx != 4) tick();
        rst = 1'b1;
        tick();
        check("t6_rst_dig", oDIG, 32'd0);
        check("t6_rst_blank", oBLANK, 8'hFF);
        check("t6_rst_valid", oVALID, 1'b0);
        rst = 1'b0;
        wait_valid(n);
        check("t6_latency", n, 32);
        check("t6_changed", oCHANGED, 1'b1);

        // Randomized frames with occasional short glitches
        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < 8; i++) begin
                k = $urandom_range(0, 9);
                if (k < 7)       seg_in[i] = tbl[$urandom_range(0, 15)];
                else if (k == 7) seg_in[i] = 7'h7F;
                else             seg_in[i] = 7'($urandom_range(0, 127));
            end
            run($urandom_range(3, 60));
            if ($urandom_range(0, 3) == 0) begin
                k = $urandom_range(0, 7);
                tmp[6:0] = seg_in[k];
                seg_in[k] = 7'($urandom_range(0, 127));
                run($urandom_range(1, 6));
                seg_in[k] = tmp[6:0];
                run($urandom_range(20, 50));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
